// File: rtl/lsu.sv
// lsu: load/store unit, initiator side of the data-memory port.
// Accepts byte/half/word loads and stores, drives a word-aligned bus with
// per-byte strobes and returns sign/zero-extended load data.
//
// Build option: LSU_MISALIGNED_SPLIT_EN
//   defined   - accesses crossing a 32-bit word are split into ACC0 + ACC1
//   undefined - crossing accesses fault (resp_err) with no bus writes
//
// state | meaning
// IDLE  | ready for a request; latch req_* on req_valid
// ACC0  | bus cycle on the word holding the first byte
// ACC1  | bus cycle on the following word (split builds only)
// DONE  | one-cycle response pulse
module lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wrdata,
  output logic [3:0]  mem_wrstb,
  input  logic [31:0] mem_rddata
);

  typedef logic [3:0] wrstb_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC0 = 2'd1,
    S_ACC1 = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state, state_nxt;

  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] rd0;
  // Only the low three bytes of the second word can ever land in a result.
  logic [23:0] rd1;

  logic [1:0]  off;
  logic [7:0]  size_mask;
  logic [7:0]  lane_mask;
  logic [31:0] lane_lo;
`ifdef LSU_MISALIGNED_SPLIT_EN
  logic [31:0] lane_hi;
`endif
  logic        size_bad;
  logic        crosses;
  logic        fault;
  logic [31:0] word_addr;
  logic [31:0] rd_shift;
  logic [31:0] load_ext;
  wrstb_t      strobe;

  // Lane mask, lane-aligned store data and fault decode from the latched request.
  always_comb begin
    off       = lat_addr[1:0];
    size_bad  = (lat_size == 2'b11);
    case (lat_size)
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'h00;
    endcase
    lane_mask = size_mask << off;
    crosses   = |lane_mask[7:4];
`ifdef LSU_MISALIGNED_SPLIT_EN
    {lane_hi, lane_lo} = {32'd0, lat_wdata} << {off, 3'b000};
    fault = size_bad;
`else
    lane_lo = lat_wdata << {off, 3'b000};
    fault   = size_bad | crosses;
`endif
    word_addr = {lat_addr[31:2], 2'b00};
  end

  // Align the captured word pair down to the requested byte, then extend.
  always_comb begin
    case (off)
      2'd0:    rd_shift = rd0;
      2'd1:    rd_shift = {rd1[7:0],  rd0[31:8]};
      2'd2:    rd_shift = {rd1[15:0], rd0[31:16]};
      default: rd_shift = {rd1[23:0], rd0[31:24]};
    endcase
    case (lat_size)
      2'b00:   load_ext = {{24{lat_signed & rd_shift[7]}},  rd_shift[7:0]};
      2'b01:   load_ext = {{16{lat_signed & rd_shift[15]}}, rd_shift[15:0]};
      default: load_ext = rd_shift;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request latch and read-data capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_we     <= 1'b0;
      lat_size   <= 2'b00;
      lat_signed <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      rd0        <= 32'd0;
      rd1        <= 24'd0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        lat_we     <= req_we;
        lat_size   <= req_size;
        lat_signed <= req_signed;
        lat_addr   <= req_addr;
        lat_wdata  <= req_wdata;
        rd0        <= 32'd0;
        rd1        <= 24'd0;
      end
      if (state == S_ACC0) begin
        rd0 <= mem_rddata;
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      if (state == S_ACC1) begin
        rd1 <= mem_rddata[23:0];
      end
`endif
    end
  end

  // Next-state and bus/response outputs.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    resp_err   = 1'b0;
    mem_addr   = 32'd0;
    mem_wrdata = 32'd0;
    strobe     = '0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = S_ACC0;
        end
      end
      S_ACC0: begin
        mem_addr   = word_addr;
        mem_wrdata = lane_lo;
        if (lat_we && !fault) begin
          strobe = lane_mask[3:0];
        end
`ifdef LSU_MISALIGNED_SPLIT_EN
        state_nxt = (crosses && !size_bad) ? S_ACC1 : S_DONE;
`else
        state_nxt = S_DONE;
`endif
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      S_ACC1: begin
        mem_addr   = word_addr + 32'd4;
        mem_wrdata = lane_hi;
        if (lat_we) begin
          strobe = lane_mask[7:4];
        end
        state_nxt = S_DONE;
      end
`endif
      S_DONE: begin
        resp_valid = 1'b1;
        resp_err   = fault;
        if (!fault && !lat_we) begin
          resp_rdata = load_ext;
        end
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // A reset landing on a bus cycle must not commit that cycle's bytes.
  assign mem_wrstb = rst_n ? strobe : 4'b0000;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit: the initiator side of the data-memory port. Accepts byte/half/word load and store requests from the core, drives word-aligned `mem_addr`, lane-aligned `mem_wrdata` and per-byte `mem_wrstb` toward data memory, and returns sign- or zero-extended load data. Accesses that cross a 32-bit word boundary are split into two consecutive bus cycles. Sits between the execute stage and data memory.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  core clock; one clock domain
- `rst_n`  in  1  reset; synchronous, active-low
- `req_valid`  in  1  core request present
- `req_ready`  out  1  LSU can accept; high only in IDLE
- `req_we`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 invalid
- `req_signed`  in  1  sign-extend load result
- `req_addr`  in  32  byte address, any alignment
- `req_wdata`  in  32  store data, right-justified
- `resp_valid`  out  1  one-cycle response pulse
- `resp_rdata`  out  32  extended load data; 0 for stores and errors
- `resp_err`  out  1  request faulted; qualifies `resp_valid`
- `mem_addr`  out  32  word address, bits [1:0] always 00
- `mem_wrdata`  out  32  lane-aligned store data
- `mem_wrstb`  out  4  byte write strobes (`wrstb_t`)
- `mem_rddata`  in  32  combinational read data for current `mem_addr`

## Operation
- State machine: IDLE -> ACC0 -> (ACC1) -> DONE -> IDLE.
- IDLE: `req_ready`=1; on `req_valid` latch all `req_*` fields, go ACC0.
- Let o = addr[1:0], n = 1/2/4 bytes, m = (2^n − 1) << o (8-bit), d = wdata << 8·o (64-bit).
- ACC0: `mem_addr` = {addr[31:2],00}; `mem_wrstb` = m[3:0] if store else 0; `mem_wrdata` = d[31:0]; capture `mem_rddata` into rd0. Go ACC1 if m[7:4]≠0, else DONE.
- ACC1: `mem_addr` = {addr[31:2],00} + 4 (32-bit wrap: 0xFFFFFFFC+4 = 0); strobe m[7:4] for stores; `mem_wrdata` = d[63:32]; capture rd1. Go DONE.
- DONE: `resp_valid`=1; load result = ({rd1,rd0} >> 8·o) truncated to n bytes, sign-extended if `req_signed`, else zero-extended. Word loads ignore `req_signed`. Go IDLE.
- `req_size`=11: no bus activity (strobe 0 in ACC0), skip ACC1, `resp_err`=1, `resp_rdata`=0.
- Outside ACC0/ACC1: `mem_addr`=0, `mem_wrdata`=0, `mem_wrstb`=0.

## Timing
- Reset (rst_n=0 at posedge): state IDLE; all outputs 0 except `req_ready`=1 after first reset edge; latched request cleared.
- Non-crossing access: accept at edge 0, bus cycle 1, `resp_valid` cycle 2. Crossing: bus cycles 1–2, `resp_valid` cycle 3.
- Writes commit at the edge ending each ACC cycle; a split store commits lower part at end of ACC0, upper at end of ACC1.
- Reset asserted in ACC1: lower store part already committed stays; no upper strobe, no response.
- `req_valid` outside IDLE is ignored (`req_ready`=0); no back-to-back accept in DONE.
- `resp_valid` is a one-cycle pulse; no response backpressure.

## Configuration
- `LSU_MISALIGNED_SPLIT_EN` defined: crossing accesses split as above.
- Undefined: ACC1 removed; any access with m[7:4]≠0 forces `mem_wrstb`=0 in ACC0, then DONE with `resp_err`=1, `resp_rdata`=0; no memory modified. Non-crossing misaligned accesses (e.g. half at o=1) still succeed.

## Test plan
- SW addr 0x10 data 0xDEADBEEF -> ACC0 `mem_addr`=0x10, strobe 1111, wrdata 0xDEADBEEF; LW 0x10 -> `resp_rdata`=0xDEADBEEF at cycle 2.
- SB 0x13 data 0x000000A5 -> strobe 1000, wrdata 0xA5000000; LB signed 0x13 -> 0xFFFFFFA5; LBU -> 0x000000A5.
- SH 0x23 data 0x1234 (split EN) -> ACC0 addr 0x20 strobe 1000 wrdata 0x34000000; ACC1 addr 0x24 strobe 0001 wrdata 0x00000012; LH signed 0x23 -> 0x00001234, `resp_valid` at cycle 3.
- Same SH 0x23 with macro undefined -> no strobes, `resp_err`=1, memory unchanged at 0x20/0x24.
- LW 0xFFFFFFFE (split EN) -> ACC1 `mem_addr`=0x00000000; result = {mem[1:0 of word 0], mem[3:2 of word 0xFFFFFFFC]}.
- `req_size`=11 -> `resp_err`=1 cycle 2; reset during ACC1 of split store -> upper lane not written, `resp_valid` never asserted, `req_ready`=1 next cycle.
